alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 operand  input  10  operand[9:5] = A, operand[4:0] = B, both unsigned 0..31.
REQ-004 opcode  input  6  one-hot operation select.
REQ-005 d1..d6  output  7 each  seven-segment digit patterns, d1 leftmost, d6 rightmost.
- Bit order {g,f,e,d,c,b,a}; 1 = segment lit.

Function
REQ-006 The opcode encodings SHALL be:
- 100000 ADD: A+B.
- 010000 SUB: signed A-B.
- 001000 MUL: A*B.
- 000100 DIV: quotient and remainder of A/B.
- 000010 XOR: A^B, shown in decimal.
- 000001 SQR: B*B.
REQ-007 Opcode 000000, or any opcode that is not one-hot, SHALL blank all six digits.
REQ-008 Inputs SHALL be sampled on each rising clk edge; d1..d6 SHALL be registered and reflect that sample after 1 cycle; no handshake.
REQ-009 Non-DIV display layout:
- d1 = '-' if the result is negative, else blank.
- d2, d3 blank.
- d4/d5/d6 = hundreds/tens/units of |result|; maximum 961.
REQ-010 DIV display layout:
- d1/d2 = quotient tens/units.
- d3 blank.
- d4 = 'r'.
- d5/d6 = remainder tens/units.
REQ-011 DIV with B=0 SHALL show d1..d3 blank and d4/d5/d6 = 'E','r','r'.
REQ-012 Glyph codes SHALL be:
- Digits 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
- '-' 40, 'E' 79, 'r' 50, blank 00.
REQ-013 Internal arithmetic SHALL be at least 11 bits wide so no result wraps.
REQ-014 An opcode or operand change SHALL take effect in full on the next edge; there is no partial or stale digit state.

Reset
REQ-015 While rst=1, d1..d6 SHALL be 7'h00 immediately, regardless of clk.
REQ-016 After rst is released, the first rising edge SHALL load a normal result.
REQ-017 Asserting rst mid-operation SHALL discard the pending result.

Configuration
REQ-018 Macro ALU_LEADING_ZERO_BLANK_EN:
- Defined: leading zero digits within each numeric field are blank; the units digit is always shown.
- Undefined: leading zeros are shown as '0' (3F).

Structure
REQ-019 Package alu_pkg SHALL hold the opcode constants, the glyph constants and the result-width constant.
REQ-020 A sub-module seg7_decoder SHALL map a 4-bit glyph index (0-9, minus, E, r, blank) to a 7-bit pattern.
- alu SHALL instantiate seg7_decoder six times.

Verification
REQ-021 The bench SHALL cover these directed scenarios, with ALU_LEADING_ZERO_BLANK_EN defined unless noted:
- rst=1 with any opcode -> d1..d6 = 00 asynchronously.
- ADD A=0, B=23 -> d5=5B, d6=4F, others 00.
- Same ADD with ALU_LEADING_ZERO_BLANK_EN undefined -> d4=3F.
- SUB A=11, B=19 -> d1=40, d6=7F, others 00.
- MUL A=11, B=19 (209) -> d4=5B, d5=3F, d6=6F.
- DIV A=1, B=22 -> d2=3F, d4=50, d6=06, others 00.
- DIV with B=0 -> d4..d6 = 79, 50, 50.
- XOR A=13, B=10 -> d6=07.
- SQR B=20 -> d4=66, d5=3F, d6=3F.
- Opcode 000000, then 000011 -> all 00 one cycle after each is applied.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/glyph constants and BCD helpers for the seven-segment ALU.
// Glyph indices 0-9 are decimal digits; the rest select symbols or blank.
package alu_pkg;

    localparam int RES_W = 11;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b010000;
    localparam logic [5:0] OP_MUL = 6'b001000;
    localparam logic [5:0] OP_DIV = 6'b000100;
    localparam logic [5:0] OP_XOR = 6'b000010;
    localparam logic [5:0] OP_SQR = 6'b000001;

    typedef logic [3:0] glyph_t;

    localparam glyph_t GLYPH_MINUS = 4'd10;
    localparam glyph_t GLYPH_E     = 4'd11;
    localparam glyph_t GLYPH_R     = 4'd12;
    localparam glyph_t GLYPH_BLANK = 4'd13;

    // Segment order {g,f,e,d,c,b,a}; entry 0 is the digit '0'.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic [3:0] hun;
        logic [3:0] ten;
        logic [3:0] uni;
    } bcd3_t;

    typedef struct packed {
        logic [3:0] ten;
        logic [3:0] uni;
    } bcd2_t;

    // Shift-and-add-3; results never exceed 961 so three digits suffice.
    function automatic bcd3_t bin2bcd3(input logic [RES_W-1:0] bin);
        logic [RES_W+11:0] sh;
        sh = {12'd0, bin};
        for (int i = 0; i < RES_W; i++) begin
            if (sh[RES_W+3:RES_W] > 4'd4)    sh[RES_W+3:RES_W]    = sh[RES_W+3:RES_W] + 4'd3;
            if (sh[RES_W+7:RES_W+4] > 4'd4)  sh[RES_W+7:RES_W+4]  = sh[RES_W+7:RES_W+4] + 4'd3;
            if (sh[RES_W+11:RES_W+8] > 4'd4) sh[RES_W+11:RES_W+8] = sh[RES_W+11:RES_W+8] + 4'd3;
            sh = sh << 1;
        end
        return bcd3_t'(sh[RES_W+11:RES_W]);
    endfunction

    function automatic bcd2_t bin2bcd2(input logic [4:0] bin);
        logic [12:0] sh;
        sh = {8'd0, bin};
        for (int i = 0; i < 5; i++) begin
            if (sh[8:5] > 4'd4)  sh[8:5]  = sh[8:5] + 4'd3;
            if (sh[12:9] > 4'd4) sh[12:9] = sh[12:9] + 4'd3;
            sh = sh << 1;
        end
        return bcd2_t'(sh[12:5]);
    endfunction

    // A zero digit becomes blank only when the caller says it is a leading zero.
    function automatic glyph_t digit_glyph(input logic [3:0] d, input logic may_blank);
        return (may_blank && d == 4'd0) ? GLYPH_BLANK : glyph_t'(d);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Maps a 4-bit glyph index (digit, minus, E, r, blank) to a {g..a} segment pattern.
module seg7_decoder
    import alu_pkg::*;
(
    input  logic [3:0] glyph_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (glyph_i < 4'd10) begin
            seg_o = SEG_DIGITS[glyph_i];
        end else begin
            case (glyph_i)
                GLYPH_MINUS: seg_o = SEG_MINUS;
                GLYPH_E:     seg_o = SEG_E;
                GLYPH_R:     seg_o = SEG_R;
                default:     seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/alu.sv
// Five-bit ALU driving six registered seven-segment digits (d1 leftmost).
// Build option ALU_LEADING_ZERO_BLANK_EN blanks leading zeros in each numeric field.
module alu
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] operand,
    input  logic [5:0] opcode,
    output logic [6:0] d1,
    output logic [6:0] d2,
    output logic [6:0] d3,
    output logic [6:0] d4,
    output logic [6:0] d5,
    output logic [6:0] d6
);

`ifdef ALU_LEADING_ZERO_BLANK_EN
    localparam logic LZ_BLANK = 1'b1;
`else
    localparam logic LZ_BLANK = 1'b0;
`endif

    logic [4:0]       a;
    logic [4:0]       b;
    logic [RES_W-1:0] mag;
    logic             neg;
    logic             op_valid;
    logic             op_div;
    logic             div_by_zero;
    logic [4:0]       quo;
    logic [4:0]       rem;
    bcd3_t            mag_bcd;
    bcd2_t            quo_bcd;
    bcd2_t            rem_bcd;
    glyph_t           glyph [6];
    logic [6:0]       seg_d [6];
    logic [6:0]       seg_q [6];

    assign a = operand[9:5];
    assign b = operand[4:0];

    // Signed results are carried as sign + magnitude, which is what the display needs.
    always_comb begin
        mag      = '0;
        neg      = 1'b0;
        op_valid = 1'b1;
        op_div   = 1'b0;
        case (opcode)
            OP_ADD: mag = RES_W'(a) + RES_W'(b);
            OP_SUB: begin
                if (a < b) begin
                    neg = 1'b1;
                    mag = RES_W'(b) - RES_W'(a);
                end else begin
                    mag = RES_W'(a) - RES_W'(b);
                end
            end
            OP_MUL:  mag = RES_W'(a) * RES_W'(b);
            OP_DIV:  op_div = 1'b1;
            OP_XOR:  mag = RES_W'(a ^ b);
            OP_SQR:  mag = RES_W'(b) * RES_W'(b);
            default: op_valid = 1'b0;
        endcase
    end

    assign div_by_zero = (b == 5'd0);
    assign quo         = div_by_zero ? 5'd0 : a / b;
    assign rem         = div_by_zero ? 5'd0 : a % b;

    assign mag_bcd = bin2bcd3(mag);
    assign quo_bcd = bin2bcd2(quo);
    assign rem_bcd = bin2bcd2(rem);

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            glyph[i] = GLYPH_BLANK;
        end
        if (op_valid) begin
            if (op_div) begin
                if (div_by_zero) begin
                    glyph[3] = GLYPH_E;
                    glyph[4] = GLYPH_R;
                    glyph[5] = GLYPH_R;
                end else begin
                    glyph[0] = digit_glyph(quo_bcd.ten, LZ_BLANK);
                    glyph[1] = digit_glyph(quo_bcd.uni, 1'b0);
                    glyph[3] = GLYPH_R;
                    glyph[4] = digit_glyph(rem_bcd.ten, LZ_BLANK);
                    glyph[5] = digit_glyph(rem_bcd.uni, 1'b0);
                end
            end else begin
                glyph[0] = neg ? GLYPH_MINUS : GLYPH_BLANK;
                glyph[3] = digit_glyph(mag_bcd.hun, LZ_BLANK);
                glyph[4] = digit_glyph(mag_bcd.ten, LZ_BLANK && (mag_bcd.hun == 4'd0));
                glyph[5] = digit_glyph(mag_bcd.uni, 1'b0);
            end
        end
    end

    // Decode before the register so every digit changes together on one edge.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            seg7_decoder u_dec (
                .glyph_i (glyph[gi]),
                .seg_o   (seg_d[gi])
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    seg_q[gi] <= SEG_BLANK;
                end else begin
                    seg_q[gi] <= seg_d[gi];
                end
            end
        end
    endgenerate

    assign d1 = seg_q[0];
    assign d2 = seg_q[1];
    assign d3 = seg_q[2];
    assign d4 = seg_q[3];
    assign d5 = seg_q[4];
    assign d6 = seg_q[5];

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues hand-computed digit patterns, monitor checks them.
// Leading-zero expectations follow ALU_LEADING_ZERO_BLANK_EN as built.
module tb_alu;

`ifdef ALU_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] Z = 7'h00;
`else
    localparam logic [6:0] Z = 7'h3F;
`endif

    typedef struct {
        string            name;
        logic [5:0][6:0]  d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] operand;
    logic [5:0] opcode;
    logic [6:0] d1, d2, d3, d4, d5, d6;

    exp_t sb_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu dut (
        .clk     (clk),
        .rst     (rst),
        .operand (operand),
        .opcode  (opcode),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .d4      (d4),
        .d5      (d5),
        .d6      (d6)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0][6:0] got_digits();
        return {d6, d5, d4, d3, d2, d1};
    endfunction

    task automatic compare(input string name, input logic [5:0][6:0] exp_d);
        logic [5:0][6:0] g;
        g = got_digits();
        n_cmp++;
        if (g !== exp_d) begin
            n_err++;
            $display("FAIL %s: got d1..d6=%h %h %h %h %h %h required %h %h %h %h %h %h",
                     name, g[0], g[1], g[2], g[3], g[4], g[5],
                     exp_d[0], exp_d[1], exp_d[2], exp_d[3], exp_d[4], exp_d[5]);
        end else begin
            $display("ok   %s: d1..d6=%h %h %h %h %h %h",
                     name, g[0], g[1], g[2], g[3], g[4], g[5]);
        end
    endtask

    task automatic apply(input string name, input logic [5:0] op, input int a, input int b,
                         input logic [6:0] e1, input logic [6:0] e2, input logic [6:0] e3,
                         input logic [6:0] e4, input logic [6:0] e5, input logic [6:0] e6);
        exp_t e;
        @(negedge clk);
        opcode  = op;
        operand = {a[4:0], b[4:0]};
        e.name  = name;
        e.d     = {e6, e5, e4, e3, e2, e1};
        sb_q.push_back(e);
    endtask

    // Monitor: outputs are registered, so each queued vector is visible just after the next edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                compare(e.name, e.d);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        opcode  = 6'b100000;
        operand = {5'd0, 5'd23};
        repeat (2) @(posedge clk);
        #1 compare("rst_hold", '0);
        @(negedge clk);
        rst = 1'b0;

        apply("add_0_23",   6'b100000,  0, 23, 7'h00, 7'h00, 7'h00, Z,     7'h5B, 7'h4F);
        apply("sub_11_19",  6'b010000, 11, 19, 7'h40, 7'h00, 7'h00, Z,     Z,     7'h7F);
        apply("mul_11_19",  6'b001000, 11, 19, 7'h00, 7'h00, 7'h00, 7'h5B, 7'h3F, 7'h6F);
        apply("div_1_22",   6'b000100,  1, 22, Z,     7'h3F, 7'h00, 7'h50, Z,     7'h06);
        apply("div_7_0",    6'b000100,  7,  0, 7'h00, 7'h00, 7'h00, 7'h79, 7'h50, 7'h50);
        apply("xor_13_10",  6'b000010, 13, 10, 7'h00, 7'h00, 7'h00, Z,     Z,     7'h07);
        apply("sqr_b20",    6'b000001,  5, 20, 7'h00, 7'h00, 7'h00, 7'h66, 7'h3F, 7'h3F);
        apply("op_none",    6'b000000,  9,  9, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        apply("add_31_31",  6'b100000, 31, 31, 7'h00, 7'h00, 7'h00, Z,     7'h7D, 7'h5B);
        apply("op_multi",   6'b000011,  9,  9, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        apply("sub_31_0",   6'b010000, 31,  0, 7'h00, 7'h00, 7'h00, Z,     7'h4F, 7'h06);
        apply("sub_0_31",   6'b010000,  0, 31, 7'h40, 7'h00, 7'h00, Z,     7'h4F, 7'h06);
        apply("sub_5_5",    6'b010000,  5,  5, 7'h00, 7'h00, 7'h00, Z,     Z,     7'h3F);
        apply("div_31_1",   6'b000100, 31,  1, 7'h4F, 7'h06, 7'h00, 7'h50, Z,     7'h3F);
        apply("div_30_7",   6'b000100, 30,  7, Z,     7'h66, 7'h00, 7'h50, Z,     7'h5B);
        apply("xor_31_0",   6'b000010, 31,  0, 7'h00, 7'h00, 7'h00, Z,     7'h4F, 7'h06);
        apply("mul_31_31",  6'b001000, 31, 31, 7'h00, 7'h00, 7'h00, 7'h6F, 7'h7D, 7'h06);

        // Reset mid-operation: clears at once and the pending SQR never appears.
        @(negedge clk);
        opcode  = 6'b000001;
        operand = {5'd0, 5'd20};
        #2 rst = 1'b1;
        #1 compare("rst_async", '0);
        @(posedge clk);
        #1 compare("rst_discard", '0);
        @(negedge clk);
        rst = 1'b0;
        apply("post_rst_add", 6'b100000, 0, 23, 7'h00, 7'h00, 7'h00, Z, 7'h5B, 7'h4F);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #3;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending vectors required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
